// File: rtl/qcorr_acc_if.sv
// qcorr_acc_if: per-channel sample handshake and drained-result handshake of qcorr_acc_scheduler
interface qcorr_acc_if #(
  parameter int NUM_CH = 4,
  parameter int ACC_W = 16
);
  logic [NUM_CH-1:0] ch_valid_i, ch_data_i, ch_ready_o;
  logic res_valid_o, res_ready_i;
  logic [$clog2(NUM_CH)-1:0] res_ch_o;
  logic signed [ACC_W-1:0] res_data_o;
  modport master (
    output ch_valid_i, ch_data_i, res_ready_i,
    input ch_ready_o, res_valid_o, res_ch_o, res_data_o
  );
  modport slave (
    input ch_valid_i, ch_data_i, res_ready_i,
    output ch_ready_o, res_valid_o, res_ch_o, res_data_o
  );
endinterface

// File: rtl/qcorr_acc_scheduler.sv
// qcorr_acc_scheduler: round-robin shared +-1 accumulator over NUM_CH QCorr streams with in-order result drain.
// Define QCORR_ACC_SAT_EN for saturating accumulation; default build wraps modulo 2^ACC_W.
module qcorr_acc_scheduler #(
  parameter int NUM_CH = 4,
  parameter int SAMPLING_RATE = 48,
  parameter int TIME_WINDOW = 10,
  parameter int FEATURE_MAP_RESOLUTION = 8,
  parameter int ACC_W = 2 * FEATURE_MAP_RESOLUTION
) (
  input  logic clk_i,
  input  logic rst_i,
  qcorr_acc_if.slave bus,
  output logic window_done_o,
  output logic busy_o
);
  localparam int CH_W = $clog2(NUM_CH);
  localparam logic [15:0] TOTAL = 16'(SAMPLING_RATE * TIME_WINDOW);
  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, CLEAR} state_t;
  state_t state, state_nxt;
  logic signed [ACC_W-1:0] acc [NUM_CH];
  logic [15:0] cnt [NUM_CH];
  logic [CH_W-1:0] last_grant, idx, g, gc;
  logic [NUM_CH-1:0] elig, full_nxt;
  logic found, all_done;
  logic signed [ACC_W-1:0] acc_g, step, acc_nxt;
  int c;
`ifdef QCORR_ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] MAXV = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {1'b1, {(ACC_W-1){1'b0}}};
`endif
  // Rotating priority search starting just after the last granted channel
  always_comb begin
    elig = '0;
    found = 1'b0;
    g = '0;
    gc = '0;
    c = 0;
    for (int k = 0; k < NUM_CH; k++) elig[k] = state == COLLECT && bus.ch_valid_i[k] && cnt[k] != TOTAL;
    for (int k = 0; k < NUM_CH; k++) begin
      c = int'(last_grant) + 1 + k;
      c = c >= NUM_CH ? c - NUM_CH : c;
      gc = c[CH_W-1:0];
      if (!found && elig[gc]) begin
        found = 1'b1;
        g = gc;
      end
    end
  end
  // Window completion is judged on post-handshake counts so DRAIN follows the final sample directly
  always_comb begin
    acc_g = acc[g];
    step = bus.ch_data_i[g] ? ACC_W'(1) : '1;
`ifdef QCORR_ACC_SAT_EN
    acc_nxt = (bus.ch_data_i[g] ? acc_g == MAXV : acc_g == MINV) ? acc_g : acc_g + step;
`else
    acc_nxt = acc_g + step;
`endif
    for (int k = 0; k < NUM_CH; k++)
      full_nxt[k] = cnt[k] == TOTAL || (found && g == CH_W'(k) && cnt[k] == TOTAL - 16'd1);
    all_done = &full_nxt;
  end
  always_comb begin
    state_nxt = state == IDLE    ? COLLECT :
                state == COLLECT ? (all_done ? DRAIN : COLLECT) :
                state == DRAIN   ? (bus.res_ready_i && idx == CH_W'(NUM_CH - 1) ? CLEAR : DRAIN) :
                                   COLLECT;
  end
  assign bus.ch_ready_o = found ? NUM_CH'(1) << g : '0;
  assign bus.res_valid_o = state == DRAIN;
  assign bus.res_ch_o = state == DRAIN ? idx : '0;
  assign bus.res_data_o = state == DRAIN ? acc[idx] : '0;
  assign window_done_o = state == CLEAR;
  assign busy_o = state != IDLE;
  always_ff @(posedge clk_i) state <= rst_i ? IDLE : state_nxt;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_CH; k++) begin
        acc[k] <= '0;
        cnt[k] <= '0;
      end
      last_grant <= CH_W'(NUM_CH - 1);
      idx <= '0;
    end else begin
      if (state == CLEAR) begin
        for (int k = 0; k < NUM_CH; k++) begin
          acc[k] <= '0;
          cnt[k] <= '0;
        end
      end else if (found) begin
        acc[g] <= acc_nxt;
        cnt[g] <= cnt[g] + 16'd1;
      end
      if (found) last_grant <= g;
      if (state == COLLECT && all_done) idx <= '0;
      else if (state == DRAIN && bus.res_ready_i) idx <= idx + CH_W'(1);
    end
  end
endmodule

// File: tb/tb_qcorr_acc_scheduler.sv
// tb_qcorr_acc_scheduler: directed checks of arbitration, drain, stall, reset, back-to-back windows and accumulator width limits
module tb_qcorr_acc_scheduler;
  logic clk = 1'b0, rst = 1'b1, rst2 = 1'b1;
  logic wdone, busy, wdone2, busy2;
  int total = 0, bad = 0, wd_pulses = 0;
  int cnt_m [4];
  int last_m = 3;
  int exp_res [4] = '{480, -480, 0, 120};
`ifdef QCORR_ACC_SAT_EN
  int exp_sat [2] = '{127, -128};
`else
  int exp_sat [2] = '{-56, 56};
`endif
  always #5 clk = ~clk;
  always @(negedge clk) if (wdone) wd_pulses++;
  qcorr_acc_if #(.NUM_CH(4), .ACC_W(16)) bif();
  qcorr_acc_if #(.NUM_CH(2), .ACC_W(8)) sif();
  qcorr_acc_scheduler #(.NUM_CH(4), .SAMPLING_RATE(48), .TIME_WINDOW(10), .ACC_W(16)) u_dut (
    .clk_i(clk), .rst_i(rst), .bus(bif.slave), .window_done_o(wdone), .busy_o(busy));
  qcorr_acc_scheduler #(.NUM_CH(2), .SAMPLING_RATE(20), .TIME_WINDOW(10), .ACC_W(8)) u_sat (
    .clk_i(clk), .rst_i(rst2), .bus(sif.slave), .window_done_o(wdone2), .busy_o(busy2));
  function automatic logic pat(input int ch, input int n);
    return ch == 0 ? 1'b1 : ch == 1 ? 1'b0 : ch == 2 ? (n % 2 == 0) : (n < 300);
  endfunction
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (bif.ch_ready_o !== 4'b0 || bif.res_valid_o !== 1'b0 || bif.res_ch_o !== 2'd0 ||
        bif.res_data_o !== 16'sd0 || wdone !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset: ready=%b rv=%b ch=%0d data=%0d wd=%b busy=%b, want all zero",
               bif.ch_ready_o, bif.res_valid_o, bif.res_ch_o, bif.res_data_o, wdone, busy);
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) cnt_m[k] = 0;
    last_m = 3;
  endtask
  task automatic collect(input logic [3:0] vm, input int n);
    int eg, cc;
    logic [3:0] er;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        bif.ch_valid_i[k] = vm[k];
        bif.ch_data_i[k] = pat(k, cnt_m[k]);
      end
      #1;
      eg = -1;
      for (int k = 1; k <= 4; k++) begin
        cc = (last_m + k) % 4;
        if (eg < 0 && vm[cc] && cnt_m[cc] < 480) eg = cc;
      end
      er = eg < 0 ? 4'b0 : 4'(1 << eg);
      total++;
      if (bif.ch_ready_o !== er) begin
        bad++;
        $display("FAIL grant step %0d: ready=%b want %b", i, bif.ch_ready_o, er);
      end
      total++;
      if (bif.res_valid_o !== 1'b0 || wdone !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL collect_status step %0d: rv=%b wd=%b busy=%b want 0 0 1", i, bif.res_valid_o, wdone, busy);
      end
      if (eg >= 0) begin
        cnt_m[eg]++;
        last_m = eg;
      end
    end
  endtask
  task automatic drain(input int stall);
    @(negedge clk);
    for (int s = 0; s < stall; s++) begin
      bif.res_ready_i = 1'b0;
      #1;
      total++;
      if (bif.res_valid_o !== 1'b1 || bif.res_ch_o !== 2'd0 || bif.res_data_o !== 16'(exp_res[0])) begin
        bad++;
        $display("FAIL stall_hold %0d: rv=%b ch=%0d data=%0d want 1 0 %0d", s, bif.res_valid_o, bif.res_ch_o, bif.res_data_o, exp_res[0]);
      end
      @(negedge clk);
    end
    for (int k = 0; k < 4; k++) begin
      bif.res_ready_i = 1'b1;
      #1;
      total++;
      if (bif.res_valid_o !== 1'b1 || bif.res_ch_o !== 2'(k) || bif.res_data_o !== 16'(exp_res[k]) ||
          bif.ch_ready_o !== 4'b0 || wdone !== 1'b0) begin
        bad++;
        $display("FAIL result %0d: rv=%b ch=%0d data=%0d ready=%b wd=%b want 1 %0d %0d 0000 0",
                 k, bif.res_valid_o, bif.res_ch_o, bif.res_data_o, bif.ch_ready_o, wdone, k, exp_res[k]);
      end
      @(negedge clk);
    end
    bif.res_ready_i = 1'b0;
    #1;
    total++;
    if (wdone !== 1'b1 || bif.res_valid_o !== 1'b0 || bif.ch_ready_o !== 4'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL clear: wd=%b rv=%b ready=%b busy=%b want 1 0 0000 1", wdone, bif.res_valid_o, bif.ch_ready_o, busy);
    end
    for (int k = 0; k < 4; k++) cnt_m[k] = 0;
  endtask
  task automatic test_main();
    collect(4'hF, 1920);
    drain(0);
  endtask
  task automatic test_only_ch2();
    collect(4'b0100, 480);
    collect(4'b0100, 10);
    collect(4'b1011, 1440);
    drain(0);
  endtask
  task automatic test_stall();
    collect(4'hF, 1920);
    drain(5);
  endtask
  task automatic test_reset_mid();
    collect(4'hF, 800);
    test_reset();
    collect(4'hF, 1920);
    drain(0);
  endtask
  task automatic test_back_to_back();
    int p0;
    p0 = wd_pulses;
    collect(4'hF, 1920);
    drain(0);
    collect(4'hF, 1920);
    drain(0);
    @(negedge clk);
    total++;
    if (wd_pulses - p0 !== 2) begin
      bad++;
      $display("FAIL window_done_count: got %0d want 2", wd_pulses - p0);
    end
  endtask
  task automatic test_sat();
    int t;
    @(negedge clk);
    rst2 = 1'b0;
    t = 0;
    while (sif.res_valid_o !== 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    total++;
    if (t >= 1000) begin
      bad++;
      $display("FAIL sat_timeout: res_valid never rose, waited %0d cycles want < 1000", t);
    end else begin
      for (int k = 0; k < 2; k++) begin
        total++;
        if (sif.res_valid_o !== 1'b1 || sif.res_ch_o !== 1'(k) || sif.res_data_o !== 8'(exp_sat[k])) begin
          bad++;
          $display("FAIL acc_width ch%0d: rv=%b ch=%0d data=%0d want 1 %0d %0d", k, sif.res_valid_o, sif.res_ch_o, sif.res_data_o, k, exp_sat[k]);
        end
        @(negedge clk);
      end
      total++;
      if (wdone2 !== 1'b1) begin
        bad++;
        $display("FAIL sat_clear: wd=%b want 1", wdone2);
      end
    end
  endtask
  initial begin
    bif.ch_valid_i = '1;
    bif.ch_data_i = '0;
    bif.res_ready_i = 1'b0;
    sif.ch_valid_i = 2'b11;
    sif.ch_data_i = 2'b01;
    sif.res_ready_i = 1'b1;
    test_reset();
    test_main();
    test_only_ch2();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_sat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
